// File: rtl/arm_pkg.sv
// Shared encodings for the ARM decode path: condition codes, modes, opcodes,
// ALU commands, status bit positions and the control bundle handed to EXE.
package arm_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned NUM_REGS  = 15;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned CMD_W     = 4;

  // ALU commands
  localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
  localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

  // Data-processing opcodes, instruction[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
    COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
  } cond_e;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_stage_register_file.sv
// Architectural register file R0..R14: reset to R[i]=i, one write port from WB,
// two combinational read ports with write-through bypass; index 15 reads as 0.
module register_file #(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             wr_ok;

  assign wr_ok = wr_en && (wr_idx < IDX_W'(NUM_REGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= WIDTH'(i);
    end else if (wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // PC slot is not stored, so it never bypasses and always reads zero
  assign rd_data_a = (rd_idx_a >= IDX_W'(NUM_REGS)) ? '0 :
                     (wr_en && (wr_idx == rd_idx_a)) ? wr_data : regs[rd_idx_a];
  assign rd_data_b = (rd_idx_b >= IDX_W'(NUM_REGS)) ? '0 :
                     (wr_en && (wr_idx == rd_idx_b)) ? wr_data : regs[rd_idx_b];

endmodule

// File: rtl/id_stage.sv
// ARM decode stage: condition check, EXE/MEM/WB control generation, operand
// fetch from the register file and source reporting to the hazard unit.
module id_stage
  import arm_pkg::*;
#(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [31:0]      instruction,
  input  logic [3:0]       status,
  input  logic             hazard,
  input  logic             wb_wb_en,
  input  logic [3:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  output logic [WIDTH-1:0] pc,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             b,
  output logic             s,
  output logic [3:0]       exe_cmd,
  output logic [WIDTH-1:0] val_rn,
  output logic [WIDTH-1:0] val_rm,
  output logic             imm,
  output logic [11:0]      shift_operand,
  output logic [23:0]      signed_imm_24,
  output logic [3:0]       dest,
  output logic [3:0]       src1,
  output logic [3:0]       src2,
  output logic             two_src
);

  mode_e      mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       is_store;
  logic       cond_pass;
  ctrl_t      raw_ctrl;
  ctrl_t      ctrl;

  logic flag_n, flag_z, flag_c, flag_v;

  assign mode   = mode_e'(instruction[27:26]);
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign flag_n = status[FLAG_N];
  assign flag_z = status[FLAG_Z];
  assign flag_c = status[FLAG_C];
  assign flag_v = status[FLAG_V];

  // Store is decoded ungated so the hazard unit sees Rd as a source even in a bubble
  assign is_store = (mode == MODE_MEM) && !s_bit;

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond_e'(instruction[31:28]))
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = !flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = !flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = !flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = !flag_v;
      COND_HI: cond_pass = flag_c && !flag_z;
      COND_LS: cond_pass = !flag_c || flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = !flag_z && (flag_n == flag_v);
      COND_LE: cond_pass = flag_z || (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    raw_ctrl = CTRL_NONE;
    unique case (mode)
      MODE_DP: begin
        raw_ctrl.s = s_bit;
        case (opcode)
          OP_MOV:  begin raw_ctrl.exe_cmd = EXE_MOV; raw_ctrl.wb_en = 1'b1; end
          OP_MVN:  begin raw_ctrl.exe_cmd = EXE_MVN; raw_ctrl.wb_en = 1'b1; end
          OP_ADD:  begin raw_ctrl.exe_cmd = EXE_ADD; raw_ctrl.wb_en = 1'b1; end
          OP_ADC:  begin raw_ctrl.exe_cmd = EXE_ADC; raw_ctrl.wb_en = 1'b1; end
          OP_SUB:  begin raw_ctrl.exe_cmd = EXE_SUB; raw_ctrl.wb_en = 1'b1; end
          OP_SBC:  begin raw_ctrl.exe_cmd = EXE_SBC; raw_ctrl.wb_en = 1'b1; end
          OP_AND:  begin raw_ctrl.exe_cmd = EXE_AND; raw_ctrl.wb_en = 1'b1; end
          OP_ORR:  begin raw_ctrl.exe_cmd = EXE_ORR; raw_ctrl.wb_en = 1'b1; end
          OP_EOR:  begin raw_ctrl.exe_cmd = EXE_EOR; raw_ctrl.wb_en = 1'b1; end
          OP_CMP:  raw_ctrl.exe_cmd = EXE_SUB;
          OP_TST:  raw_ctrl.exe_cmd = EXE_AND;
          default: raw_ctrl.exe_cmd = EXE_NOP;
        endcase
      end
      MODE_MEM: begin
        raw_ctrl.exe_cmd = EXE_ADD;
        if (s_bit) begin
          raw_ctrl.mem_r_en = 1'b1;
          raw_ctrl.wb_en    = 1'b1;
          raw_ctrl.s        = 1'b1;
        end else begin
          raw_ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BR:  raw_ctrl.b = 1'b1;
      default:  raw_ctrl = CTRL_NONE;
    endcase
  end

  assign ctrl = (hazard || !cond_pass) ? CTRL_NONE : raw_ctrl;

  assign wb_en    = ctrl.wb_en;
  assign mem_r_en = ctrl.mem_r_en;
  assign mem_w_en = ctrl.mem_w_en;
  assign b        = ctrl.b;
  assign s        = ctrl.s;
  assign exe_cmd  = ctrl.exe_cmd;

  assign pc            = pc_in;
  assign imm           = instruction[25];
  assign shift_operand = instruction[11:0];
  assign signed_imm_24 = instruction[23:0];
  assign dest          = instruction[15:12];
  assign src1          = instruction[19:16];
  assign src2          = is_store ? instruction[15:12] : instruction[3:0];
  assign two_src       = !instruction[25] || is_store;

  register_file #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH),
    .IDX_W    (REG_IDX_W)
  ) u_register_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_wb_en),
    .wr_idx    (wb_dest),
    .wr_data   (wb_value),
    .rd_idx_a  (src1),
    .rd_idx_b  (src2),
    .rd_data_a (val_rn),
    .rd_data_b (val_rm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reset-state register reads, a decode vector table and
// hand-written bypass / write-to-R15 / mid-stream reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic        hazard;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [31:0] pc;
  logic        wb_en, mem_r_en, mem_w_en, b, s;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest, src1, src2;
  logic        two_src;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
    .status(status), .hazard(hazard), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .pc(pc), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .b(b), .s(s), .exe_cmd(exe_cmd), .val_rn(val_rn),
    .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest), .src1(src1), .src2(src2),
    .two_src(two_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, src1, src2;
    logic        two_src;
  } out_t;

  // ctl packs {wb_en, mem_r_en, mem_w_en, b, s}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        hazard;
    logic [4:0]  ctl;
    logic [3:0]  exe;
    logic [31:0] rn, rm;
    logic [3:0]  src2;
    logic        two_src;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_vec(input string nm, input logic [31:0] ins, input logic [3:0] st,
                         input logic hz, input logic [4:0] ctl, input logic [3:0] exe,
                         input logic [31:0] rn, input logic [31:0] rm,
                         input logic [3:0] s2, input logic ts);
    vec_t v;
    v.name = nm; v.instr = ins; v.status = st; v.hazard = hz; v.ctl = ctl;
    v.exe = exe; v.rn = rn; v.rm = rm; v.src2 = s2; v.two_src = ts;
    vecs.push_back(v);
  endtask

  // Builds the expectation from the bench's own drive values, then compares 1ns later
  task automatic expect_now(input string nm, input logic [4:0] ctl, input logic [3:0] exe,
                            input logic [31:0] rn, input logic [31:0] rm,
                            input logic [3:0] s2, input logic ts);
    out_t e, g;
    e.pc = pc_in;
    {e.wb_en, e.mem_r_en, e.mem_w_en, e.b, e.s} = ctl;
    e.exe_cmd = exe;
    e.val_rn = rn;
    e.val_rm = rm;
    e.imm = instruction[25];
    e.shift_operand = instruction[11:0];
    e.signed_imm_24 = instruction[23:0];
    e.dest = instruction[15:12];
    e.src1 = instruction[19:16];
    e.src2 = s2;
    e.two_src = ts;
    sb.push_back(e);
    #1;
    g = {pc, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, val_rn, val_rm, imm,
         shift_operand, signed_imm_24, dest, src1, src2, two_src};
    e = sb.pop_front();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] st, input logic hz,
                       input logic we, input logic [3:0] wd, input logic [31:0] wv);
    @(negedge clk);
    instruction = ins;
    status = st;
    hazard = hz;
    wb_wb_en = we;
    wb_dest = wd;
    wb_value = wv;
    pc_in = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pc_in = '0; instruction = '0; status = '0; hazard = 1'b0;
    wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;

    add_vec("add",        32'hE0821003, 4'h0, 1'b0, 5'b10000, 4'h2, 32'd2, 32'd3, 4'd3, 1'b1);
    add_vec("moveq_fail", 32'h03A01005, 4'h0, 1'b0, 5'b00000, 4'h0, 32'd0, 32'd5, 4'd5, 1'b0);
    add_vec("moveq_pass", 32'h03A01005, 4'h4, 1'b0, 5'b10000, 4'h1, 32'd0, 32'd5, 4'd5, 1'b0);
    add_vec("str",        32'hE5821004, 4'h0, 1'b0, 5'b00100, 4'h2, 32'd2, 32'd1, 4'd1, 1'b1);
    add_vec("ldr",        32'hE5921004, 4'h0, 1'b0, 5'b11001, 4'h2, 32'd2, 32'd4, 4'd4, 1'b1);
    add_vec("branch",     32'hEA000003, 4'h0, 1'b0, 5'b00010, 4'h0, 32'd0, 32'd3, 4'd3, 1'b0);
    add_vec("branch_hz",  32'hEA000003, 4'h0, 1'b1, 5'b00000, 4'h0, 32'd0, 32'd3, 4'd3, 1'b0);
    add_vec("cmps",       32'hE1520003, 4'h0, 1'b0, 5'b00001, 4'h4, 32'd2, 32'd3, 4'd3, 1'b1);
    add_vec("cond_nv",    32'hF0821003, 4'hF, 1'b0, 5'b00000, 4'h0, 32'd2, 32'd3, 4'd3, 1'b1);
    add_vec("mvngt",      32'hC1E01004, 4'h9, 1'b0, 5'b10000, 4'h9, 32'd0, 32'd4, 4'd4, 1'b1);
    add_vec("mvnlt_fail", 32'hB1E01004, 4'h9, 1'b0, 5'b00000, 4'h0, 32'd0, 32'd4, 4'd4, 1'b1);
    add_vec("undef_op",   32'hE0621003, 4'h0, 1'b0, 5'b00000, 4'h0, 32'd2, 32'd3, 4'd3, 1'b1);
    add_vec("mode_nop",   32'hEC000000, 4'h0, 1'b0, 5'b00000, 4'h0, 32'd0, 32'd0, 4'd0, 1'b1);
    add_vec("orrhis",     32'h81923004, 4'h2, 1'b0, 5'b10001, 4'h7, 32'd2, 32'd4, 4'd4, 1'b1);
    add_vec("zero_z1",    32'h00000000, 4'h4, 1'b0, 5'b10000, 4'h6, 32'd0, 32'd0, 4'd0, 1'b1);
    add_vec("zero_z0",    32'h00000000, 4'h0, 1'b0, 5'b00000, 4'h0, 32'd0, 32'd0, 4'd0, 1'b1);
    add_vec("add_hazard", 32'hE0821003, 4'h0, 1'b1, 5'b00000, 4'h0, 32'd2, 32'd3, 4'd3, 1'b1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset image R[i] = i, read as Rn=i / Rm=14-i pairs
    for (int i = 0; i < 15; i++) begin
      drive({12'hE08, 4'(i), 4'h1, 8'h00, 4'(14 - i)}, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0);
      expect_now("reset_image", 5'b10000, 4'h2, 32'(i), 32'(14 - i), 4'(14 - i), 1'b1);
    end

    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].status, vecs[k].hazard, 1'b0, 4'h0, 32'h0);
      expect_now(vecs[k].name, vecs[k].ctl, vecs[k].exe, vecs[k].rn, vecs[k].rm,
                 vecs[k].src2, vecs[k].two_src);
    end

    // Same-cycle bypass, then the stored value after the write edge
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1, 4'd2, 32'h55);
    expect_now("bypass_same_cycle", 5'b10000, 4'h2, 32'h55, 32'd3, 4'd3, 1'b1);
    drive(32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("bypass_stored", 5'b10000, 4'h2, 32'h55, 32'd3, 4'd3, 1'b1);

    // Write to index 15 is dropped
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1, 4'd15, 32'hDEADBEEF);
    expect_now("wr15_same_cycle", 5'b10000, 4'h2, 32'h55, 32'd3, 4'd3, 1'b1);
    drive(32'hE08E1000, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("wr15_r14_r0", 5'b10000, 4'h2, 32'd14, 32'd0, 4'd0, 1'b1);
    drive(32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("wr15_r2_r3", 5'b10000, 4'h2, 32'h55, 32'd3, 4'd3, 1'b1);
    drive(32'hE08F100F, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("r15_reads_zero", 5'b10000, 4'h2, 32'd0, 32'd0, 4'd15, 1'b1);

    // R3 <- 0xAA, then asynchronous reset in mid-cycle
    drive(32'hE0821003, 4'h0, 1'b0, 1'b1, 4'd3, 32'hAA);
    expect_now("r3_bypass", 5'b10000, 4'h2, 32'h55, 32'hAA, 4'd3, 1'b1);
    drive(32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("r3_stored", 5'b10000, 4'h2, 32'h55, 32'hAA, 4'd3, 1'b1);
    #2;
    rst = 1'b1;
    expect_now("reset_mid_regs", 5'b10000, 4'h2, 32'd2, 32'd3, 4'd3, 1'b1);
    instruction = 32'hF0821003;
    status = 4'hF;
    expect_now("reset_mid_nv", 5'b00000, 4'h0, 32'd2, 32'd3, 4'd3, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(32'hE0821003, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_now("after_reset", 5'b10000, 4'h2, 32'd2, 32'd3, 4'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage ARM pipeline. Sits directly downstream of the IF pipeline register and upstream of the ID/EXE pipeline register.
- Takes the fetched instruction and its PC, and reads the register file.
- Evaluates the condition field against the status flags, generates EXE/MEM/WB control, and reports source registers to the hazard unit.
- Owns the architectural register file, which the WB stage writes.

Parameters:
- NUM_REGS, 15, general registers R0..R14 (R15/PC not stored).
- WIDTH, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_in  in  32  PC+4 from IF register, passed through
- instruction  in  32  instruction from IF register
- status  in  4  {N,Z,C,V} from status register
- hazard  in  1  hazard unit request to bubble this instruction
- wb_wb_en  in  1  write-back enable from WB stage
- wb_dest  in  4  write-back register index
- wb_value  in  32  write-back data
- pc  out  32  = pc_in
- wb_en  out  1  register write enable for this instruction
- mem_r_en  out  1  load
- mem_w_en  out  1  store
- b  out  1  branch taken
- s  out  1  update status (data processing) / L bit (memory)
- exe_cmd  out  4  ALU command
- val_rn  out  32  Rn contents
- val_rm  out  32  second operand register contents
- imm  out  1  instruction bit 25
- shift_operand  out  12  instruction[11:0]
- signed_imm_24  out  24  instruction[23:0]
- dest  out  4  instruction[15:12]
- src1  out  4  instruction[19:16]
- src2  out  4  Rd if store, else instruction[3:0]
- two_src  out  1  ~imm | mem_w_en

Behaviour:
- Register file:
  - 15 x 32 storage. On async reset, R[i] <= i (i = 0..14).
  - Write at posedge clk when wb_wb_en=1 and wb_dest<15. A write to index 15 is ignored.
  - Reads are combinational with write-through bypass: if wb_wb_en=1 and wb_dest equals the read index, the read returns wb_value in the same cycle.
  - Reading index 15 returns 0.
- Reset mid-operation: the register file reinitialises immediately. All other outputs are combinational functions of the inputs, so there is no other state.
- Condition check: 4-bit cond field instruction[31:28], standard ARM encodings.
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1.
  - cond 1111 evaluates false.
- Mode field instruction[27:26]:
  - 00 = data processing: opcode [24:21], S [20].
  - 01 = memory: L [20].
  - 10 = branch.
  - 11 = no-op (all control 0).
- Data-processing opcode -> exe_cmd, wb_en:
  - MOV 1101 -> 0001, 1.
  - MVN 1111 -> 1001, 1.
  - ADD 0100 -> 0010, 1.
  - ADC 0101 -> 0011, 1.
  - SUB 0010 -> 0100, 1.
  - SBC 0110 -> 0101, 1.
  - AND 0000 -> 0110, 1.
  - ORR 1100 -> 0111, 1.
  - EOR 0001 -> 1000, 1.
  - CMP 1010 -> 0100, 0.
  - TST 1000 -> 0110, 0.
  - Other opcodes -> exe_cmd 0000, wb_en 0.
  - s = S bit.
- Memory:
  - L=1 (LDR): exe_cmd 0010, mem_r_en=1, wb_en=1, s=1.
  - L=0 (STR): exe_cmd 0010, mem_w_en=1, wb_en=0, s=0.
- Branch: b=1, exe_cmd 0000, no other control asserted.
- Bubble: if condition false OR hazard=1, then wb_en, mem_r_en, mem_w_en, b, s are all 0 and exe_cmd = 0000.
  - Data fields (val_*, dest, src*, imm, shift_operand, signed_imm_24, pc) are unaffected by a bubble.
  - two_src and src1/src2 are also unaffected, so the hazard unit keeps seeing real sources.
- A zero instruction (IF flush bubble, cond EQ, AND R0,R0,R0) is treated normally. It is gated only by the condition check; no special casing.

Decomposition:
- Package arm_pkg holds:
  - exe_cmd constants (EXE_MOV, EXE_ADD, ...).
  - Data-processing opcode constants.
  - Condition-code constants.
  - Mode constants (MODE_DP, MODE_MEM, MODE_BR).
  - Status bit indices (N=3, Z=2, C=1, V=0).
- One sub-module is natural: register_file (storage, reset init, bypassed dual read).
- Condition check and control decode stay as combinational blocks inside id_stage.

Test Plan:
- Reset, instruction=0xE0821003 (ADD R1,R2,R3), status=0 -> exe_cmd=0010, wb_en=1, val_rn=2, val_rm=3, dest=1, src1=2, src2=3, two_src=1.
- Same ADD with wb_wb_en=1, wb_dest=2, wb_value=0x55 -> val_rn=0x55 in the same cycle; after posedge with wb_wb_en=0, val_rn still 0x55. Then wb_dest=15 write -> no register changes.
- instruction=0x03A01005 (MOVEQ R1,#5):
  - status=0000 -> wb_en=0, exe_cmd=0000.
  - status=0100 -> wb_en=1, exe_cmd=0001, imm=1, shift_operand=0x005, two_src=0.
- instruction=0xE5821004 (STR R1,[R2,#4]) -> mem_w_en=1, wb_en=0, exe_cmd=0010, src1=2, src2=1, val_rm=1, two_src=1. With L set (0xE5921004) -> mem_r_en=1, wb_en=1, s=1.
- instruction=0xEA000003 (B) -> b=1, signed_imm_24=0x000003, wb_en=0. Same instruction with hazard=1 -> b=0, signed_imm_24 still 0x000003.
- Write R3=0xAA, then assert rst mid-stream -> val_rm for ADD reads 3 immediately; all control for cond=1111 instruction is 0.
